// File: rtl/raizing_pcm_bankarb.sv
// raizing_pcm_bankarb
// Shares one PCM ROM port between up to four OKI ADPCM chips.
//
// Each chip has a 4-entry bank table that maps its 18-bit sample address
// into the wider ROM space. Each chip also keeps a one-byte cache made of
// the served address and its data. RD_OK tells the chip whether that
// cached byte still matches the address it is asking for. A round-robin
// arbiter fetches bytes for chips whose cache misses.
//
// Build option: define PCM_TOC_PAGE_EN to bank the phrase table with
// addr[9:8] instead of addr[17:16]. The phrase table is every address
// below 0x400.
module raizing_pcm_bankarb #(
    parameter int CHIPS = 2,
    parameter int AW    = 18,
    parameter int OUTW  = 22
) (
    input  logic                CLK96,
    input  logic                RESET96,
    input  logic                BANK_WE,
    input  logic [3:0]          BANK_SEL,
    input  logic [7:0]          BANK_DATA,
    input  logic [CHIPS*AW-1:0] REQ_ADDR,
    output logic [CHIPS*8-1:0]  RD_DATA,
    output logic [CHIPS-1:0]    RD_OK,
    output logic                PCM_CS,
    output logic [OUTW-1:0]     PCM_ADDR,
    input  logic [7:0]          PCM_DOUT,
    input  logic                PCM_OK
);

    // Wide enough to slice addr[17:16] even when AW is narrower.
    localparam int XW = (AW > 18) ? AW : 18;

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT } state_t;

    state_t           state;
    state_t           state_nx;
    logic [7:0]       bank_reg    [CHIPS][4];
    logic [AW-1:0]    served_addr [CHIPS];
    logic [CHIPS-1:0] valid;
    logic [CHIPS-1:0] pending;
    logic [1:0]       ptr;
    logic [1:0]       gnt;
    logic [1:0]       pick;
    logic             pick_any;
    int               rr_dist;
    int               rr_best;
    logic [AW-1:0]    pick_addr;
    logic [AW-1:0]    fetch_addr;
    logic [XW-1:0]    pick_xaddr;
    logic [1:0]       bank_idx;
    logic [7:0]       bank_val;
    logic [OUTW-1:0]  xlat_addr;

    // Per-chip hit flags: the cached byte is good only while the chip still asks for the served address.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        RD_OK = '0;
        for (int i = 0; i < CHIPS; i++) begin
            RD_OK[i] = valid[i] && (REQ_ADDR[i*AW +: AW] == served_addr[i]);
        end
        pending = ~RD_OK;
    end

    // Round-robin pick: first pending chip at or after the pointer.
    always_comb begin
        rr_best = CHIPS;
        rr_dist = 0;
        pick    = 2'd0;
        for (int i = 0; i < CHIPS; i++) begin
            rr_dist = i - int'(ptr);
            if (rr_dist < 0) rr_dist = rr_dist + CHIPS;
            if (pending[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                pick    = 2'(i);
            end
        end
        pick_any = |pending;
    end

    // Translate the picked chip's address through its bank table.
    always_comb begin
        pick_addr = '0;
        bank_val  = '0;
        for (int i = 0; i < CHIPS; i++) begin
            if (pick == 2'(i)) pick_addr = REQ_ADDR[i*AW +: AW];
        end
        pick_xaddr = XW'(pick_addr);
        bank_idx   = pick_xaddr[17:16];
`ifdef PCM_TOC_PAGE_EN
        if (pick_xaddr[XW-1:10] == '0) bank_idx = pick_xaddr[9:8];
`endif
        for (int i = 0; i < CHIPS; i++) begin
            if (pick == 2'(i)) bank_val = bank_reg[i][bank_idx];
        end
        xlat_addr = OUTW'({bank_val, pick_xaddr[15:0]});
    end

    // Arbiter state register.
    always_ff @(posedge CLK96) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
        if (RESET96) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state. ISSUE lasts one cycle so that WAIT never sees a PCM_OK left over from the previous fetch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (PCM_OK) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ROM request is asserted for the whole fetch.
    always_comb begin
        PCM_CS = (state == ISSUE) || (state == WAIT);
    end

    // Grant latch, frozen ROM address, capture into the per-chip cache and pointer advance.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            ptr        <= 2'd0;
            gnt        <= 2'd0;
            fetch_addr <= '0;
            PCM_ADDR   <= '0;
            valid      <= '0;
            RD_DATA    <= '0;
            for (int i = 0; i < CHIPS; i++) served_addr[i] <= '0;
        end else begin
            if ((state == IDLE) && pick_any) begin
                gnt        <= pick;
                fetch_addr <= pick_addr;
                PCM_ADDR   <= xlat_addr;
            end
            if ((state == WAIT) && PCM_OK) begin
                for (int i = 0; i < CHIPS; i++) begin
                    if (gnt == 2'(i)) begin
                        RD_DATA[i*8 +: 8] <= PCM_DOUT;
                        served_addr[i]    <= fetch_addr;
                        valid[i]          <= 1'b1;
                    end
                end
                if (int'(gnt) >= CHIPS - 1) ptr <= 2'd0;
                else                        ptr <= gnt + 2'd1;
            end
        end
    end

    // Bank table. Writes to a chip index at or above CHIPS match no entry and are dropped.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            // NOTE: the bank table is built from flops rather than RAM, so it is reset to the identity map.
            for (int i = 0; i < CHIPS; i++) begin
                for (int n = 0; n < 4; n++) bank_reg[i][n] <= 8'(n);
            end
        end else if (BANK_WE) begin
            for (int i = 0; i < CHIPS; i++) begin
                for (int n = 0; n < 4; n++) begin
                    if ((BANK_SEL[3:2] == 2'(i)) && (BANK_SEL[1:0] == 2'(n)))
                        bank_reg[i][n] <= BANK_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_raizing_pcm_bankarb.sv
// tb_raizing_pcm_bankarb
// Bench for the PCM bank arbiter.
//
// The bench pushes the expected ROM addresses into a queue as it drives the
// chip addresses. A monitor pops the queue on every new PCM_CS request.
// Returned bytes are compared against a ROM model.
module tb_raizing_pcm_bankarb;

    localparam int CHIPS = 2;
    localparam int AW    = 18;
    localparam int OUTW  = 22;

    logic                CLK96 = 1'b0;
    logic                RESET96;
    logic                BANK_WE;
    logic [3:0]          BANK_SEL;
    logic [7:0]          BANK_DATA;
    logic [CHIPS*AW-1:0] REQ_ADDR;
    logic [CHIPS*8-1:0]  RD_DATA;
    logic [CHIPS-1:0]    RD_OK;
    logic                PCM_CS;
    logic [OUTW-1:0]     PCM_ADDR;
    logic [7:0]          PCM_DOUT;
    logic                PCM_OK;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [OUTW-1:0] sb_q[$];
    logic [OUTW-1:0] mon_exp;
    logic            prev_cs = 1'b0;

    raizing_pcm_bankarb #(.CHIPS(CHIPS), .AW(AW), .OUTW(OUTW)) dut (
        .CLK96    (CLK96),
        .RESET96  (RESET96),
        .BANK_WE  (BANK_WE),
        .BANK_SEL (BANK_SEL),
        .BANK_DATA(BANK_DATA),
        .REQ_ADDR (REQ_ADDR),
        .RD_DATA  (RD_DATA),
        .RD_OK    (RD_OK),
        .PCM_CS   (PCM_CS),
        .PCM_ADDR (PCM_ADDR),
        .PCM_DOUT (PCM_DOUT),
        .PCM_OK   (PCM_OK)
    );

    always #5 CLK96 = ~CLK96;

    // ROM contents model: a byte derived from every address bit.
    function automatic logic [7:0] rom(input logic [OUTW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    assign PCM_DOUT = rom(PCM_ADDR);

    // Monitor: every new ROM request must match the next expected address.
    always @(negedge CLK96) begin
        if (PCM_CS === 1'b1 && prev_cs !== 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: PCM_ADDR=%h, expected no request", PCM_ADDR);
            end else begin
                mon_exp = sb_q.pop_front();
                if (PCM_ADDR !== mon_exp) begin
                    n_fail++;
                    $display("FAIL fetch_addr: PCM_ADDR=%h, expected %h", PCM_ADDR, mon_exp);
                end
            end
        end
        prev_cs = PCM_CS;
    end

    // Global time limit.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK96);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK96);
    endtask

    task automatic set_addr(input int chip, input logic [AW-1:0] a);
        REQ_ADDR[chip*AW +: AW] = a;
    endtask

    task automatic bank_write(input logic [3:0] sel, input logic [7:0] d);
        BANK_SEL  = sel;
        BANK_DATA = d;
        BANK_WE   = 1'b1;
        step();
        BANK_WE   = 1'b0;
    endtask

    // Waits until every chip hits and no fetch is in progress. Gives up after a fixed number of cycles.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        #1;
        while (!(RD_OK === '1 && PCM_CS === 1'b0) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: RD_OK=%b PCM_CS=%b, expected all hits and idle", tag, RD_OK, PCM_CS);
        end
    endtask

    task automatic test_reset();
        RESET96   = 1'b1;
        BANK_WE   = 1'b0;
        BANK_SEL  = '0;
        BANK_DATA = '0;
        PCM_OK    = 1'b1;
        REQ_ADDR  = '0;
        set_addr(0, 18'h00123);
        set_addr(1, 18'h00456);
        repeat (3) step();
        sample();
        n_checks++;
        if (PCM_CS !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b expected 0", PCM_CS); end
        n_checks++;
        if (PCM_ADDR !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", PCM_ADDR); end
        n_checks++;
        if (RD_OK !== '0) begin n_fail++; $display("FAIL reset_rd_ok: got %b expected 00", RD_OK); end
        n_checks++;
        if (RD_DATA !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", RD_DATA); end
        sb_q.push_back(22'h000123);
        sb_q.push_back(22'h000456);
        step();
        RESET96 = 1'b0;
        // Cycle 1 is IDLE, cycle 2 is ISSUE, cycle 3 is WAIT and RD_OK rises in cycle 4.
        sample();
        n_checks++;
        if (RD_OK[0] !== 1'b0 || PCM_CS !== 1'b0) begin
            n_fail++; $display("FAIL latency_c1: RD_OK0=%b CS=%b expected 0 0", RD_OK[0], PCM_CS);
        end
        sample();
        n_checks++;
        if (PCM_CS !== 1'b1 || PCM_ADDR !== 22'h000123) begin
            n_fail++; $display("FAIL latency_c2: CS=%b ADDR=%h expected 1 000123", PCM_CS, PCM_ADDR);
        end
        sample();
        n_checks++;
        if (RD_OK[0] !== 1'b0) begin n_fail++; $display("FAIL latency_c3: RD_OK0=%b expected 0", RD_OK[0]); end
        sample();
        n_checks++;
        if (RD_OK[0] !== 1'b1 || RD_DATA[7:0] !== rom(22'h000123)) begin
            n_fail++; $display("FAIL latency_c4: RD_OK0=%b data=%h expected 1 %h", RD_OK[0], RD_DATA[7:0], rom(22'h000123));
        end
        step();
        wait_idle("reset");
        n_checks++;
        if (RD_DATA[15:8] !== rom(22'h000456)) begin
            n_fail++; $display("FAIL reset_chip1_data: got %h expected %h", RD_DATA[15:8], rom(22'h000456));
        end
    endtask

    task automatic test_bank_translate();
        bank_write(4'h1, 8'h0A);
        bank_write(4'b1001, 8'hFF);  // chip index 2 does not exist and must be dropped
        sb_q.push_back(22'h0AABCD);
        set_addr(0, 18'h1ABCD);
        wait_idle("bank0");
        n_checks++;
        if (RD_DATA[7:0] !== rom(22'h0AABCD)) begin
            n_fail++; $display("FAIL bank_chip0_data: got %h expected %h", RD_DATA[7:0], rom(22'h0AABCD));
        end
        // {0xC5, 0x0042} truncated to 22 bits
        bank_write(4'h7, 8'hC5);
        sb_q.push_back(22'h050042);
        set_addr(1, 18'h30042);
        wait_idle("bank1");
        n_checks++;
        if (RD_DATA[15:8] !== rom(22'h050042)) begin
            n_fail++; $display("FAIL bank_chip1_trunc: got %h expected %h", RD_DATA[15:8], rom(22'h050042));
        end
    endtask

    task automatic test_round_robin();
        // The pointer is 0 here, so chip0 is served first.
        sb_q.push_back(22'h000200);
        sb_q.push_back(22'h000300);
        set_addr(0, 18'h00200);
        set_addr(1, 18'h00300);
        wait_idle("rr_a");
        n_checks++;
        if (RD_DATA !== {rom(22'h000300), rom(22'h000200)}) begin
            n_fail++; $display("FAIL rr_a_data: got %h expected %h", RD_DATA, {rom(22'h000300), rom(22'h000200)});
        end
        // Serving chip0 alone moves the pointer to chip1.
        sb_q.push_back(22'h000201);
        set_addr(0, 18'h00201);
        wait_idle("rr_b");
        sb_q.push_back(22'h000301);
        sb_q.push_back(22'h000202);
        set_addr(0, 18'h00202);
        set_addr(1, 18'h00301);
        wait_idle("rr_c");
        n_checks++;
        if (RD_DATA !== {rom(22'h000301), rom(22'h000202)}) begin
            n_fail++; $display("FAIL rr_c_data: got %h expected %h", RD_DATA, {rom(22'h000301), rom(22'h000202)});
        end
    endtask

    task automatic test_addr_change_in_wait();
        PCM_OK = 1'b0;
        sb_q.push_back(22'h000010);
        set_addr(0, 18'h00010);
        sample();
        sample();
        sample();
        n_checks++;
        if (PCM_CS !== 1'b1 || PCM_ADDR !== 22'h000010) begin
            n_fail++; $display("FAIL chg_wait_issue: CS=%b ADDR=%h expected 1 000010", PCM_CS, PCM_ADDR);
        end
        step();
        set_addr(0, 18'h00020);
        sb_q.push_back(22'h000020);
        #1;
        n_checks++;
        if (RD_OK[0] !== 1'b0) begin n_fail++; $display("FAIL chg_rd_ok_drop: got %b expected 0", RD_OK[0]); end
        repeat (4) step();
        PCM_OK = 1'b1;
        sample();
        n_checks++;
        if (PCM_ADDR !== 22'h000010) begin
            n_fail++; $display("FAIL chg_addr_held: got %h expected 000010", PCM_ADDR);
        end
        step();
        PCM_OK = 1'b0;
        sample();
        n_checks++;
        if (RD_OK[0] !== 1'b0 || RD_DATA[7:0] !== rom(22'h000010)) begin
            n_fail++; $display("FAIL chg_old_stored: RD_OK0=%b data=%h expected 0 %h", RD_OK[0], RD_DATA[7:0], rom(22'h000010));
        end
        step();
        PCM_OK = 1'b1;
        wait_idle("chg");
        n_checks++;
        if (RD_DATA[7:0] !== rom(22'h000020)) begin
            n_fail++; $display("FAIL chg_refetch_data: got %h expected %h", RD_DATA[7:0], rom(22'h000020));
        end
    endtask

    task automatic test_bank_write_in_wait();
        PCM_OK = 1'b0;
        sb_q.push_back(22'h000500);
        set_addr(1, 18'h00500);
        sample();
        sample();
        sample();
        step();
        bank_write(4'h4, 8'h3F);
        sample();
        n_checks++;
        if (PCM_ADDR !== 22'h000500) begin
            n_fail++; $display("FAIL wr_wait_addr: got %h expected 000500", PCM_ADDR);
        end
        step();
        PCM_OK = 1'b1;
        wait_idle("wr_wait");
        n_checks++;
        if (RD_DATA[15:8] !== rom(22'h000500)) begin
            n_fail++; $display("FAIL wr_wait_data: got %h expected %h", RD_DATA[15:8], rom(22'h000500));
        end
        sb_q.push_back(22'h3F0501);
        set_addr(1, 18'h00501);
        wait_idle("wr_new");
        n_checks++;
        if (RD_DATA[15:8] !== rom(22'h3F0501)) begin
            n_fail++; $display("FAIL wr_new_bank: got %h expected %h", RD_DATA[15:8], rom(22'h3F0501));
        end
        bank_write(4'h4, 8'h00);
        repeat (3) step();
        n_checks++;
        if (RD_OK !== 2'b11) begin n_fail++; $display("FAIL wr_served_kept: got %b expected 11", RD_OK); end
    endtask

    task automatic test_toc();
        logic [OUTW-1:0] exp_a;
        logic [OUTW-1:0] exp_b;
        bank_write(4'h6, 8'h07);
`ifdef PCM_TOC_PAGE_EN
        exp_a = 22'h070212;
        exp_b = 22'h0503FF;
`else
        exp_a = 22'h000212;
        exp_b = 22'h0003FF;
`endif
        sb_q.push_back(exp_a);
        set_addr(1, 18'h00212);
        wait_idle("toc_a");
        n_checks++;
        if (RD_DATA[15:8] !== rom(exp_a)) begin
            n_fail++; $display("FAIL toc_212: got %h expected %h", RD_DATA[15:8], rom(exp_a));
        end
        sb_q.push_back(exp_b);
        set_addr(1, 18'h003FF);
        wait_idle("toc_b");
        n_checks++;
        if (RD_DATA[15:8] !== rom(exp_b)) begin
            n_fail++; $display("FAIL toc_3ff: got %h expected %h", RD_DATA[15:8], rom(exp_b));
        end
        sb_q.push_back(22'h000400);
        set_addr(1, 18'h00400);
        wait_idle("toc_c");
        n_checks++;
        if (RD_DATA[15:8] !== rom(22'h000400)) begin
            n_fail++; $display("FAIL toc_400: got %h expected %h", RD_DATA[15:8], rom(22'h000400));
        end
    endtask

    task automatic test_reset_in_wait();
        PCM_OK = 1'b0;
        sb_q.push_back(22'h0A0777);
        set_addr(0, 18'h10777);
        sample();
        sample();
        sample();
        n_checks++;
        if (PCM_CS !== 1'b1 || PCM_ADDR !== 22'h0A0777) begin
            n_fail++; $display("FAIL rst_wait_issue: CS=%b ADDR=%h expected 1 0a0777", PCM_CS, PCM_ADDR);
        end
        step();
        RESET96 = 1'b1;
        set_addr(1, 18'h10055);
        step();
        step();
        sample();
        n_checks++;
        if (PCM_CS !== 1'b0 || RD_OK !== '0 || RD_DATA !== '0) begin
            n_fail++; $display("FAIL rst_wait_state: CS=%b RD_OK=%b data=%h expected 0 00 0", PCM_CS, RD_OK, RD_DATA);
        end
        sb_q.push_back(22'h010777);
        sb_q.push_back(22'h010055);
        step();
        RESET96 = 1'b0;
        PCM_OK  = 1'b1;
        sample();
        n_checks++;
        if (PCM_CS !== 1'b0 || RD_OK !== '0) begin
            n_fail++; $display("FAIL rst_stale_ok: CS=%b RD_OK=%b expected 0 00", PCM_CS, RD_OK);
        end
        step();
        PCM_OK = 1'b0;
        sample();
        n_checks++;
        if (PCM_CS !== 1'b1 || PCM_ADDR !== 22'h010777) begin
            n_fail++; $display("FAIL rst_identity: CS=%b ADDR=%h expected 1 010777", PCM_CS, PCM_ADDR);
        end
        step();
        PCM_OK = 1'b1;
        wait_idle("rst_wait");
        n_checks++;
        if (RD_DATA !== {rom(22'h010055), rom(22'h010777)}) begin
            n_fail++; $display("FAIL rst_final_data: got %h expected %h", RD_DATA, {rom(22'h010055), rom(22'h010777)});
        end
    endtask

    initial begin
        test_reset();
        test_bank_translate();
        test_round_robin();
        test_addr_change_in_wait();
        test_bank_write_in_wait();
        test_toc();
        test_reset_in_wait();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drained: %0d requests outstanding, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
